stage_wb: RTL
=============

# stage_wb

Writeback stage of the 5-stage RV32I pipeline, directly downstream of the memory stage. Holds the MEM/WB pipeline register and extracts and extends load data from the synchronous data-memory read word, which arrives one cycle after the memory stage issues the access. Selects ALU or load result for the register file and the forwarding network, holds read data across stalls, flags misaligned loads, and keeps a retired-instruction counter.

## Interface
- `XLEN`, 32: datapath width.
- `CNT_W`, 64: width of the retire counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `me_valid` input 1: MEM stage holds a live instruction.
- `me_alu_o` input XLEN: ALU result, which is the memory address for loads.
- `me_mem_read` input 1: instruction is a load.
- `me_func3_code` input 3: load type; LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `me_reg_write` input 1: instruction writes rd.
- `me_rd` input 5: destination register.
- `me_mem_data` input XLEN: raw data-memory word, valid in the cycle after the MEM stage.
- `wb_hold` input 1: pipeline stall; freeze the WB register.
- `w_reg_write` output 1: register-file write enable.
- `w_rd` output 5: write address.
- `w_regs_data` output XLEN: write data; also the forwarding source.
- `w_misalign` output 1: current WB instruction is a misaligned load.
- `w_instret` output CNT_W: count of retired instructions.

## Operation
- MEM/WB register fields: valid, alu_o, mem_read, func3, reg_write, rd.
  - Loaded from the `me_*` inputs on each rising edge where `wb_hold`=0.
  - Unchanged while `wb_hold`=1.
- Byte offset `off` = alu_o[1:0] of the registered instruction.
- Read-data hold buffer with a 1-bit state `held`:
  - First cycle of a WB load (`held`=0): use `me_mem_data` directly.
  - If `wb_hold`=1 in that cycle: capture `me_mem_data` into the buffer and set `held`=1.
  - While `held`=1: use the buffer, ignoring `me_mem_data`.
  - `held` clears on the edge where `wb_hold`=0.
- Load extraction from the selected word D:
  - LB/LBU: D[8*off+7 : 8*off], sign- or zero-extended.
  - LH/LHU: D[16*off[1]+15 : 16*off[1]], sign- or zero-extended.
  - LW: D unchanged.
  - Unlisted func3 values: result 0.
- Misalignment:
  - `w_misalign` = valid & mem_read & ((LH/LHU & off[0]) | (LW & off≠0)).
- Writeback:
  - `w_regs_data` = mem_read ? extracted : alu_o.
  - `w_reg_write` = valid & reg_write & !w_misalign & (rd≠0).
  - `w_rd` = registered rd.
- Retire counter:
  - Increments by 1 on each edge where valid=1, `wb_hold`=0 and `w_misalign`=0.
  - Wraps modulo 2^CNT_W.

## Timing
- `rst` asserted: all pipeline register fields, the buffer, `held` and `w_instret` are 0 at once. As a result `w_reg_write`=0, `w_misalign`=0, `w_rd`=0 and `w_regs_data`=0.
- Reset in the middle of a hold: `held` is cleared, and the next load after reset takes `me_mem_data` fresh.
- Pipeline latency is one register from MEM to WB. All outputs are combinational from the WB register plus the read path.
- `w_regs_data` for a load depends combinationally on `me_mem_data`, whose clock-to-out comes from the memory macro. This is the critical path.
- `wb_hold`=1 for N cycles:
  - Outputs stay constant for all N+1 cycles.
  - `w_reg_write` may be seen asserted repeatedly. Rewriting the same value is harmless.
  - The counter increments exactly once, on the release edge.
- `wb_hold` together with `rst`: reset wins.
- A non-load instruction never sets `held`.

## Structure
- Shared package/define file:
  - Load func3 encodings LB, LH, LW, LBU, LHU. These sit alongside the existing SB/SH/SW defines.
  - `XLEN` default.
- Sub-module: `load_align`, purely combinational (D, off, func3 -> extracted value, misalign). It is reusable by a future LSU.
- Everything else is inline: the pipeline register, the hold buffer with its 1-bit state, and the counter.

## Test plan
- LB, addr 0x103, mem word 0x80FF1234:
  - `w_regs_data`=0xFFFFFF80.
  - `w_reg_write`=1.
- LHU, addr 0x102, word 0x80FF1234:
  - 0x000080FF.
- LH, addr 0x100, word 0x0000F00D:
  - 0xFFFFF00D.
- LW, addr 0x102:
  - `w_misalign`=1 and `w_reg_write`=0.
  - `w_instret` is unchanged.
- LW, addr 0x200, word 0xCAFEBABE, `wb_hold`=1 for 3 cycles, `me_mem_data` driven to 0xDEADBEEF after the first cycle:
  - Output stays 0xCAFEBABE for all cycles.
  - `w_instret` increments by exactly 1.
- ALU op with rd=x0:
  - `w_reg_write`=0.
  - The counter still increments.
- Assert `rst` during a hold:
  - Outputs and counter go to 0 immediately.
  - The next LW returns the new `me_mem_data`.

Source files
------------

// File: rtl/stage_wb_pkg.sv
// Shared definitions for the writeback stage: widths, memory func3 encodings
// and the alignment rule for loads.
package stage_wb_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 64;

    // Store encodings, kept next to the loads because they share the func3 field.
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Load encodings.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // A halfword must sit on an even address and a word on a multiple of four;
    // bytes and unlisted encodings can never be misaligned.
    function automatic logic load_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (func3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/stage_wb_load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of a
// memory word, sign- or zero-extends it, and reports misalignment.
module load_align
    import stage_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      off,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] result,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Shift the addressed lane down to bit 0, then extend according to func3.
    always_comb begin
        byte_sel = 8'(data >> {off, 3'b000});
        half_sel = 16'(data >> {off[1], 4'b0000});
        result   = '0;
        case (func3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   result = data;
            default: result = '0;
        endcase
        misalign = load_misaligned(func3, off);
    end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: MEM/WB pipeline register, read-data hold buffer for stalls,
// load extraction, register-file write control and the retire counter.
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             me_valid,
    input  logic [XLEN-1:0]  me_alu_o,
    input  logic             me_mem_read,
    input  logic [2:0]       me_func3_code,
    input  logic             me_reg_write,
    input  logic [4:0]       me_rd,
    input  logic [XLEN-1:0]  me_mem_data,
    input  logic             wb_hold,
    output logic             w_reg_write,
    output logic [4:0]       w_rd,
    output logic [XLEN-1:0]  w_regs_data,
    output logic             w_misalign,
    output logic [CNT_W-1:0] w_instret
);

    logic             valid_q,     valid_d;
    logic [XLEN-1:0]  alu_o_q,     alu_o_d;
    logic             mem_read_q,  mem_read_d;
    logic [2:0]       func3_q,     func3_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q,        rd_d;
    logic             held_q,      held_d;
    logic [XLEN-1:0]  buf_q,       buf_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    logic [XLEN-1:0]  rd_word;
    logic [XLEN-1:0]  load_result;
    logic             align_err;

    // Pipeline register advances only when the stage is not stalled.
    always_comb begin
        valid_d     = valid_q;
        alu_o_d     = alu_o_q;
        mem_read_d  = mem_read_q;
        func3_d     = func3_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        if (!wb_hold) begin
            valid_d     = me_valid;
            alu_o_d     = me_alu_o;
            mem_read_d  = me_mem_read;
            func3_d     = me_func3_code;
            reg_write_d = me_reg_write;
            rd_d        = me_rd;
        end
    end

    // The memory word is only valid for one cycle, so a stalled load keeps its copy.
    always_comb begin
        held_d = held_q;
        buf_d  = buf_q;
        if (!wb_hold) begin
            held_d = 1'b0;
        end else if (!held_q && valid_q && mem_read_q) begin
            held_d = 1'b1;
            buf_d  = me_mem_data;
        end
    end

    assign rd_word = held_q ? buf_q : me_mem_data;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .data     (rd_word),
        .off      (alu_o_q[1:0]),
        .func3    (func3_q),
        .result   (load_result),
        .misalign (align_err)
    );

    // Writeback selection and write-enable gating for the register file.
    always_comb begin
        w_misalign  = valid_q & mem_read_q & align_err;
        w_regs_data = mem_read_q ? load_result : alu_o_q;
        w_reg_write = valid_q & reg_write_q & ~w_misalign & (rd_q != 5'd0);
        w_rd        = rd_q;
    end

    // An instruction retires on the edge it leaves WB, unless it faulted.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !wb_hold && !w_misalign) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign w_instret = instret_q;

    // All stage state, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_o_q     <= '0;
            mem_read_q  <= 1'b0;
            func3_q     <= 3'b000;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            held_q      <= 1'b0;
            buf_q       <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_o_q     <= alu_o_d;
            mem_read_q  <= mem_read_d;
            func3_q     <= func3_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            held_q      <= held_d;
            buf_q       <= buf_d;
            instret_q   <= instret_d;
        end
    end

endmodule
